// File: rtl/mac_rewrite_engine.sv
// mac_rewrite_engine
//   Rewrites the destination/source MAC fields of the head beat of each
//   packet. The new addresses come from a small metadata FIFO. The pipeline
//   has a fixed latency of two cycles, inserts no bubbles and keeps beats in
//   order.
//
// Ports
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_pkt_valid/i_pkt: input beat {marker[1:0], tag[3:0], data[DATA_W-1:0]}
//                      marker 01 = head, 11 = body, 10 = tail
//   o_pkt_valid/o_pkt: output beat, same format, two cycles after input
//   i_meta_valid/i_meta: push {dst[47:0], src[47:0], ...} into the FIFO
//   i_mode           : rewrite mode, used only on head beats
//                      0 pass, 1 meta dst/src, 2 swap, 3 src<-dst, dst<-meta
//   o_meta_full      : FIFO holds META_DEPTH entries
//   o_miss_cnt       : mode 1/3 heads that found the FIFO empty
//   o_ovf_cnt        : metadata discarded because the FIFO was full
//   o_err_cnt        : framing errors (body/tail in IDLE, head inside packet)
module mac_rewrite_engine #(
  parameter int DATA_W     = 128,
  parameter int META_W     = 128,
  parameter int META_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pkt_valid,
  input  logic [DATA_W+5:0]   i_pkt,
  output logic                o_pkt_valid,
  output logic [DATA_W+5:0]   o_pkt,
  input  logic                i_meta_valid,
  input  logic [META_W-1:0]   i_meta,
  input  logic [1:0]          i_mode,
  output logic                o_meta_full,
  output logic [15:0]         o_miss_cnt,
  output logic [15:0]         o_ovf_cnt,
  output logic [15:0]         o_err_cnt
);

  localparam int PKT_W = DATA_W + 6;
  localparam int PTR_W = (META_DEPTH > 2) ? $clog2(META_DEPTH) : 1;
  localparam int CNT_W = $clog2(META_DEPTH + 1);
  localparam logic [1:0] MARK_HEAD = 2'b01;
  localparam logic [1:0] MARK_TAIL = 2'b10;

  // ---------------------------------------------------------------------
  // Input framing state machine
  // ---------------------------------------------------------------------
  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       fwd;
  logic       err_evt;
  logic [1:0] in_marker;

  assign in_marker = i_pkt[DATA_W+5 -: 2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fwd        = 1'b0;
    err_evt    = 1'b0;
    if (i_pkt_valid) begin
      case (state_reg)
        IDLE: begin
          if (in_marker == MARK_HEAD) begin
            state_next = IN_PKT;
            fwd        = 1'b1;
          end else begin
            // Body/tail with no open packet: dropped.
            err_evt = 1'b1;
          end
        end
        IN_PKT: begin
          fwd = 1'b1;
          if (in_marker == MARK_HEAD) begin
            // Missing tail: the new head starts a fresh packet.
            err_evt = 1'b1;
          end else if (in_marker == MARK_TAIL) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: registered copy of every forwarded beat
  // ---------------------------------------------------------------------
  logic             s1_valid_reg;
  logic             s1_head_reg;
  logic [1:0]       s1_mode_reg;
  logic [PKT_W-1:0] s1_pkt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_head_reg  <= 1'b0;
      s1_mode_reg  <= '0;
      s1_pkt_reg   <= '0;
    end else begin
      s1_valid_reg <= i_pkt_valid & fwd;
      s1_head_reg  <= (in_marker == MARK_HEAD);
      s1_mode_reg  <= i_mode;
      s1_pkt_reg   <= i_pkt;
    end
  end

  // ---------------------------------------------------------------------
  // Metadata FIFO. Only the 96 address bits are stored. The head is
  // resolved one cycle after its input, so an entry pushed in the head's
  // input cycle is already visible here.
  // ---------------------------------------------------------------------
  logic [95:0]      meta_mem [META_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             meta_empty;
  logic             meta_full;
  logic             need_meta;
  logic             pop;
  logic             push;
  logic             miss_evt;
  logic             ovf_evt;
  logic [95:0]      meta_rd;

  assign meta_empty = (count_reg == '0);
  assign meta_full  = (count_reg == CNT_W'(META_DEPTH));
  // Modes 1 and 3 are exactly the modes with bit 0 set.
  assign need_meta  = s1_valid_reg & s1_head_reg & s1_mode_reg[0];
  assign pop        = need_meta & ~meta_empty;
  assign miss_evt   = need_meta & meta_empty;
  // A pop in the same cycle frees a slot for a push into a full FIFO.
  assign push       = i_meta_valid & (~meta_full | pop);
  assign ovf_evt    = i_meta_valid & meta_full & ~pop;
  // Small FIFO: an asynchronous read keeps the rewrite in the pop cycle.
  assign meta_rd    = meta_mem[rd_ptr_reg];

  always_ff @(posedge i_clk) begin
    if (push) begin
      meta_mem[wr_ptr_reg] <= i_meta[META_W-1 -: 96];
    end
  end

  // Pointers wrap naturally because META_DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  generate
    if (META_W > 96) begin : g_meta_spare
      // Low metadata bits carry nothing this block uses.
      logic unused_meta_bits;
      assign unused_meta_bits = ^i_meta[META_W-97:0];
    end
  endgenerate

  assign o_meta_full = meta_full;

  // ---------------------------------------------------------------------
  // Header rewrite
  // ---------------------------------------------------------------------
  logic [47:0]      head_dst;
  logic [47:0]      head_src;
  logic [47:0]      new_dst;
  logic [47:0]      new_src;
  logic [PKT_W-1:0] out_pkt;

  assign head_dst = s1_pkt_reg[DATA_W-1  -: 48];
  assign head_src = s1_pkt_reg[DATA_W-49 -: 48];

  always_comb begin
    new_dst = head_dst;
    new_src = head_src;
    if (s1_head_reg) begin
      case (s1_mode_reg)
        2'd1: begin
          if (pop) begin
            new_dst = meta_rd[95:48];
            new_src = meta_rd[47:0];
          end
        end
        2'd2: begin
          new_dst = head_src;
          new_src = head_dst;
        end
        2'd3: begin
          if (pop) begin
            new_dst = meta_rd[95:48];
            new_src = head_dst;
          end
        end
        default: begin
          new_dst = head_dst;
          new_src = head_src;
        end
      endcase
    end
    out_pkt                     = s1_pkt_reg;
    out_pkt[DATA_W-1  -: 48]    = new_dst;
    out_pkt[DATA_W-49 -: 48]    = new_src;
  end

  // ---------------------------------------------------------------------
  // Stage 2: output register
  // ---------------------------------------------------------------------
  logic             o_valid_reg;
  logic [PKT_W-1:0] o_pkt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_reg <= 1'b0;
      o_pkt_reg   <= '0;
    end else begin
      o_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        o_pkt_reg <= out_pkt;
      end
    end
  end

  assign o_pkt_valid = o_valid_reg;
  assign o_pkt       = o_pkt_reg;

  // ---------------------------------------------------------------------
  // Saturating event counters: 0 = miss, 1 = overflow, 2 = framing error
  // ---------------------------------------------------------------------
  logic [2:0]    cnt_evt;
  logic [47:0]   cnt_flat;

  assign cnt_evt = {err_evt, ovf_evt, miss_evt};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_reg <= '0;
        end else if (cnt_evt[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign cnt_flat[gi*16 +: 16] = cnt_reg;
    end
  endgenerate

  assign o_miss_cnt = cnt_flat[15:0];
  assign o_ovf_cnt  = cnt_flat[31:16];
  assign o_err_cnt  = cnt_flat[47:32];

endmodule

// File: tb/tb_mac_rewrite_engine.sv
// Testbench for mac_rewrite_engine: directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_mac_rewrite_engine;

  localparam int DATA_W     = 128;
  localparam int META_W     = 128;
  localparam int META_DEPTH = 4;
  localparam int PW         = DATA_W + 6;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_pkt_valid;
  logic [PW-1:0]     i_pkt;
  logic              o_pkt_valid;
  logic [PW-1:0]     o_pkt;
  logic              i_meta_valid;
  logic [META_W-1:0] i_meta;
  logic [1:0]        i_mode;
  logic              o_meta_full;
  logic [15:0]       o_miss_cnt;
  logic [15:0]       o_ovf_cnt;
  logic [15:0]       o_err_cnt;

  always #5 clk = ~clk;

  mac_rewrite_engine #(
    .DATA_W(DATA_W), .META_W(META_W), .META_DEPTH(META_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
    .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt),
    .i_meta_valid(i_meta_valid), .i_meta(i_meta), .i_mode(i_mode),
    .o_meta_full(o_meta_full),
    .o_miss_cnt(o_miss_cnt), .o_ovf_cnt(o_ovf_cnt), .o_err_cnt(o_err_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [META_W-1:0] meta_q [$];
  bit                in_pkt   = 0;
  int                m_miss   = 0;
  int                m_ovf    = 0;
  int                m_err    = 0;
  bit                pend_v   = 0;
  bit                pend_head = 0;
  logic [1:0]        pend_mode;
  logic [PW-1:0]     pend_pkt;
  bit                exp_v [4];
  logic [PW-1:0]     exp_p [4];
  int                cyc      = 0;
  bit                post_rst = 0;
  logic [PW-1:0]     last_head = '0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic logic [PW-1:0] mk_pkt(input logic [1:0] mk, input logic [3:0] tag,
                                           input logic [47:0] dst, input logic [47:0] src,
                                           input logic [31:0] rest);
    return {mk, tag, dst, src, rest};
  endfunction

  function automatic logic [47:0] f_dst(input logic [PW-1:0] p);
    return p[DATA_W-1 -: 48];
  endfunction

  function automatic logic [47:0] f_src(input logic [PW-1:0] p);
    return p[DATA_W-49 -: 48];
  endfunction

  function automatic logic [PW-1:0] with_addrs(input logic [PW-1:0] p, input logic [47:0] d,
                                               input logic [47:0] s);
    logic [PW-1:0] r;
    r = p;
    r[DATA_W-1 -: 48]  = d;
    r[DATA_W-49 -: 48] = s;
    return r;
  endfunction

  // One clock cycle: check what the DUT shows now, drive the next inputs,
  // and advance the reference model by the same cycle.
  task automatic step(input logic rst, input logic pv, input logic [PW-1:0] pkt,
                      input logic mv, input logic [META_W-1:0] meta, input logic [1:0] mode);
    bit             popped;
    logic [PW-1:0]  o;
    logic [META_W-1:0] m;
    logic [1:0]     mk;
    @(negedge clk);
    if (post_rst) begin
      check_eq("rst_pkt", o_pkt, '0);
    end
    check_eq("valid", o_pkt_valid, exp_v[cyc % 4]);
    if (exp_v[cyc % 4]) check_eq("pkt", o_pkt, exp_p[cyc % 4]);
    check_eq("full", o_meta_full, (meta_q.size() == META_DEPTH));
    check_eq("miss", o_miss_cnt, m_miss[15:0]);
    check_eq("ovf", o_ovf_cnt, m_ovf[15:0]);
    check_eq("err", o_err_cnt, m_err[15:0]);
    if (o_pkt_valid && o_pkt[PW-1 -: 2] == 2'b01) last_head = o_pkt;
    exp_v[cyc % 4] = 0;

    i_rst = rst; i_pkt_valid = pv; i_pkt = pkt;
    i_meta_valid = mv; i_meta = meta; i_mode = mode;

    if (rst) begin
      meta_q.delete();
      in_pkt = 0; m_miss = 0; m_ovf = 0; m_err = 0; pend_v = 0;
      for (int k = 0; k < 4; k++) exp_v[k] = 0;
      post_rst = 1;
    end else begin
      post_rst = 0;
      popped   = 0;
      // Head accepted last cycle is resolved against the FIFO as it is now.
      if (pend_v) begin
        o = pend_pkt;
        if (pend_head) begin
          if (pend_mode == 2'd1 || pend_mode == 2'd3) begin
            if (meta_q.size() > 0) begin
              m = meta_q.pop_front();
              popped = 1;
              if (pend_mode == 2'd1) o = with_addrs(o, m[META_W-1 -: 48], m[META_W-49 -: 48]);
              else                   o = with_addrs(o, m[META_W-1 -: 48], f_dst(pend_pkt));
            end else begin
              m_miss = sat_inc(m_miss);
            end
          end else if (pend_mode == 2'd2) begin
            o = with_addrs(o, f_src(pend_pkt), f_dst(pend_pkt));
          end
        end
        exp_v[(cyc + 1) % 4] = 1;
        exp_p[(cyc + 1) % 4] = o;
      end
      pend_v = 0;
      if (mv) begin
        if (meta_q.size() < META_DEPTH || popped) meta_q.push_back(meta);
        else m_ovf = sat_inc(m_ovf);
      end
      if (pv) begin
        mk = pkt[PW-1 -: 2];
        if (!in_pkt) begin
          if (mk == 2'b01) begin in_pkt = 1; pend_v = 1; end
          else m_err = sat_inc(m_err);
        end else begin
          pend_v = 1;
          if (mk == 2'b01) m_err = sat_inc(m_err);
          else if (mk == 2'b10) in_pkt = 0;
        end
        pend_head = (mk == 2'b01);
        pend_mode = mode;
        pend_pkt  = pkt;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0, 2'd0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, '0, 2'd0);
    step(1, 0, '0, 0, '0, 2'd0);
  endtask

  logic [47:0]       a_dst;
  logic [47:0]       a_src;
  logic [META_W-1:0] mta;
  logic [PW-1:0]     hd;
  logic [PW-1:0]     rp;
  int                r;

  initial begin
    i_rst = 1; i_pkt_valid = 0; i_pkt = '0; i_meta_valid = 0; i_meta = '0; i_mode = 0;
    for (int k = 0; k < 4; k++) begin exp_v[k] = 0; exp_p[k] = '0; end
    repeat (2) @(posedge clk);
    do_reset();

    // Mode 1 rewrite from pre-pushed metadata.
    mta = {48'h112233445566, 48'hAABBCCDDEEFF, 32'h0};
    step(0, 0, '0, 1, mta, 2'd1);
    hd = mk_pkt(2'b01, 4'h5, 48'h010203040506, 48'h0708090A0B0C, 32'hCAFEF00D);
    step(0, 1, hd, 0, '0, 2'd1);
    step(0, 1, mk_pkt(2'b11, 4'h5, 48'h1, 48'h2, 32'h3), 0, '0, 2'd1);
    step(0, 1, mk_pkt(2'b10, 4'h5, 48'h4, 48'h5, 32'h6), 0, '0, 2'd1);
    idle(3);
    check_eq("m1_dst", f_dst(last_head), 48'h112233445566);
    check_eq("m1_src", f_src(last_head), 48'hAABBCCDDEEFF);
    check_eq("m1_rest", last_head[31:0], 32'hCAFEF00D);
    // FIFO must now be empty: another mode 1 head misses.
    step(0, 1, hd, 0, '0, 2'd1);
    step(0, 1, mk_pkt(2'b10, 4'h1, 48'h0, 48'h0, 32'h0), 0, '0, 2'd1);
    idle(3);
    check_eq("m1_empty_miss", o_miss_cnt, 16'd1);

    // Mode 2 swap leaves the FIFO alone.
    do_reset();
    mta = {48'h0000DEADBEEF, 48'h0000FEEDFACE, 32'h0};
    step(0, 0, '0, 1, mta, 2'd0);
    a_dst = 48'hA1A2A3A4A5A6; a_src = 48'hB1B2B3B4B5B6;
    step(0, 1, mk_pkt(2'b01, 4'h9, a_dst, a_src, 32'h77), 0, '0, 2'd2);
    step(0, 1, mk_pkt(2'b10, 4'h9, 48'h0, 48'h0, 32'h0), 0, '0, 2'd2);
    idle(3);
    check_eq("m2_dst", f_dst(last_head), a_src);
    check_eq("m2_src", f_src(last_head), a_dst);
    step(0, 1, mk_pkt(2'b01, 4'h2, a_dst, a_src, 32'h0), 0, '0, 2'd1);
    step(0, 1, mk_pkt(2'b10, 4'h2, 48'h0, 48'h0, 32'h0), 0, '0, 2'd1);
    idle(3);
    check_eq("m2_keep_meta", f_dst(last_head), 48'h0000DEADBEEF);
    check_eq("m2_no_miss", o_miss_cnt, 16'd0);

    // Mode 3 with an empty FIFO: unmodified head, one miss.
    do_reset();
    hd = mk_pkt(2'b01, 4'hC, 48'h123456789ABC, 48'hFEDCBA987654, 32'h55AA55AA);
    step(0, 1, hd, 0, '0, 2'd3);
    step(0, 1, mk_pkt(2'b10, 4'hC, 48'h0, 48'h0, 32'h0), 0, '0, 2'd3);
    idle(3);
    check_eq("m3_unmod", last_head, hd);
    check_eq("m3_miss", o_miss_cnt, 16'd1);

    // Overflow, then push alongside a pop into a full FIFO.
    do_reset();
    for (int k = 0; k <= META_DEPTH; k++)
      step(0, 0, '0, 1, {META_W{1'b0}} | META_W'(k + 1), 2'd0);
    idle(2);
    check_eq("ovf_full", o_meta_full, 1'b1);
    check_eq("ovf_cnt1", o_ovf_cnt, 16'd1);
    step(0, 1, mk_pkt(2'b01, 4'h3, 48'h1, 48'h2, 32'h0), 0, '0, 2'd1);
    step(0, 1, mk_pkt(2'b10, 4'h3, 48'h0, 48'h0, 32'h0), 1, {96'h0, 32'h99}, 2'd1);
    idle(3);
    check_eq("ovf_stays", o_ovf_cnt, 16'd1);
    check_eq("ovf_still_full", o_meta_full, 1'b1);

    // Framing errors and a reset in the middle of a packet.
    do_reset();
    step(0, 1, mk_pkt(2'b11, 4'h0, 48'h1, 48'h1, 32'h1), 0, '0, 2'd0);
    idle(3);
    check_eq("err_body", o_err_cnt, 16'd1);
    step(0, 1, mk_pkt(2'b01, 4'h4, 48'h1, 48'h2, 32'h3), 0, '0, 2'd0);
    step(0, 1, mk_pkt(2'b11, 4'h4, 48'h1, 48'h2, 32'h3), 0, '0, 2'd0);
    step(1, 0, '0, 0, '0, 2'd0);
    step(0, 1, mk_pkt(2'b11, 4'h4, 48'h4, 48'h5, 32'h6), 0, '0, 2'd0);
    step(0, 1, mk_pkt(2'b10, 4'h4, 48'h7, 48'h8, 32'h9), 0, '0, 2'd0);
    idle(3);
    check_eq("err_after_rst", o_err_cnt, 16'd2);

    // Metadata pushed in the same cycle as the head input.
    do_reset();
    mta = {48'h0A0B0C0D0E0F, 48'h102030405060, 32'h0};
    step(0, 1, mk_pkt(2'b01, 4'h6, 48'h111111111111, 48'h222222222222, 32'h0), 1, mta, 2'd1);
    step(0, 1, mk_pkt(2'b10, 4'h6, 48'h0, 48'h0, 32'h0), 0, '0, 2'd1);
    idle(3);
    check_eq("same_cyc_dst", f_dst(last_head), 48'h0A0B0C0D0E0F);
    check_eq("same_cyc_src", f_src(last_head), 48'h102030405060);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 9);
      rp = {(r < 3) ? 2'b01 : (r < 7) ? 2'b11 : 2'b10, 4'($urandom),
            $urandom, $urandom, $urandom, $urandom};
      mta = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), rp,
           ($urandom_range(0, 2) == 0), mta, 2'($urandom));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_rewrite_engine.md
MAC_REWRITE_ENGINE -- requirements
Module: mac_rewrite_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the payload width of a packet beat (multiple of 32, >= 96).
REQ-002 SHALL have parameter META_W, default 128, meaning the metadata width (>= 96).
REQ-003 SHALL have parameter META_DEPTH, default 4, meaning the metadata FIFO depth (power of 2, >= 2).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_pkt_valid, input, 1 bit: the beat on i_pkt is valid.
REQ-007 SHALL have port i_pkt, input, DATA_W+6 bits: bits [DATA_W+5:DATA_W+4] are the marker (01 head, 11 body, 10 tail); bits [DATA_W+3:DATA_W] are a pass-through tag; bits [DATA_W-1:0] are data.
REQ-008 SHALL have port o_pkt_valid, output, 1 bit: the beat on o_pkt is valid.
REQ-009 SHALL have port o_pkt, output, DATA_W+6 bits: the output beat, same format as i_pkt.
REQ-010 SHALL have port i_meta_valid, input, 1 bit: push i_meta into the metadata FIFO.
REQ-011 SHALL have port i_meta, input, META_W bits: [META_W-1:META_W-48] is the new dst MAC; [META_W-49:META_W-96] is the new src MAC.
REQ-012 SHALL have port i_mode, input, 2 bits: rewrite mode, sampled only on head beats.
REQ-013 SHALL have port o_meta_full, output, 1 bit: the FIFO holds META_DEPTH entries.
REQ-014 SHALL have ports o_miss_cnt, o_ovf_cnt and o_err_cnt, outputs, 16 bits each: saturating event counters.

Function
REQ-015 SHALL define DST = data[DATA_W-1:DATA_W-48] and SRC = data[DATA_W-49:DATA_W-96] of the head beat.
REQ-016 SHALL give a fixed latency of 2 cycles from i_pkt_valid to o_pkt_valid for every forwarded beat, with no bubbles inserted and order preserved.
REQ-017 SHALL modify only the head beat, and only its DST and SRC fields; all other bits, including tag and marker, SHALL pass unchanged.
REQ-018 SHALL apply the mode as follows:
- mode 0: pass-through.
- mode 1: DST <- meta dst, SRC <- meta src.
- mode 2: swap DST and SRC (no meta consumed).
- mode 3: SRC <- original DST, DST <- meta dst.
REQ-019 SHALL pop one FIFO entry for each head forwarded in mode 1 or 3 when the FIFO is non-empty; a head in mode 0 or 2 SHALL NOT pop.
REQ-020 SHALL base the pop decision on the FIFO state in the cycle after the head's input, so meta pushed in the same cycle as the head input is usable.
REQ-021 SHALL, when a head in mode 1 or 3 finds the FIFO empty, forward that head unmodified and increment o_miss_cnt.
REQ-022 SHALL, when i_meta_valid is asserted with the FIFO full and no pop in the same cycle, discard i_meta and increment o_ovf_cnt.
REQ-023 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle, leaving the occupancy unchanged.
REQ-024 SHALL wrap the FIFO read and write pointers modulo META_DEPTH.
REQ-025 SHALL implement an input state machine with states IDLE and IN_PKT:
- IDLE + head -> IN_PKT.
- IN_PKT + tail -> IDLE.
- IN_PKT + head: treated as a new packet, o_err_cnt incremented, stays IN_PKT.
- IN_PKT + head+tail (single beat, marker 01 followed by nothing): not applicable; a head is always followed by a tail.
REQ-026 SHALL, in IDLE, drop body and tail beats (never output them) and increment o_err_cnt.
REQ-027 SHALL saturate all counters at 16'hFFFF.
REQ-028 SHALL produce no output when i_pkt_valid is low; o_pkt contents are don't-care when o_pkt_valid is low.

Reset
REQ-029 SHALL, while i_rst is high at a clock edge, drive o_pkt_valid to 0, o_pkt to 0, and all counters to 0.
REQ-030 SHALL, on reset, empty the FIFO so that o_meta_full is 0, set the state to IDLE, and discard all in-flight beats.
REQ-031 SHALL, after a reset taken mid-packet, drop the remaining body and tail beats per REQ-026.

Verification
REQ-032 SHALL be verified with: mode 1; push meta dst=0x112233445566, src=0xAABBCCDDEEFF; then a 3-beat packet -> head out 2 cycles later with DST=0x112233445566 and SRC=0xAABBCCDDEEFF, body and tail unchanged, FIFO empty afterwards.
REQ-033 SHALL be verified with: mode 2; head with DST=A and SRC=B -> output DST=B, SRC=A; FIFO occupancy unchanged.
REQ-034 SHALL be verified with: mode 3; FIFO empty; head input -> head output unmodified; o_miss_cnt=1.
REQ-035 SHALL be verified with: META_DEPTH+1 pushes and no packets -> o_meta_full=1 and o_ovf_cnt=1; then a push in the same cycle as a pop -> o_ovf_cnt stays 1.
REQ-036 SHALL be verified with: a body beat with no preceding head -> no output and o_err_cnt=1; then reset asserted mid-packet -> trailing beats dropped and o_err_cnt counts them after reset.
REQ-037 SHALL be verified with: meta pushed in the same cycle as a mode-1 head input -> head rewritten with that meta.
